// File: rtl/signed_vector_addition_seq_pkg.sv
// Shared widths, field offsets, saturation limits and FSM encoding for the
// sequential signed vector adder.
package signed_vector_addition_seq_pkg;

   localparam int COMP_W = 19;
   localparam int VEC_W  = 3 * COMP_W;

   localparam int X_LSB = 38;
   localparam int Y_LSB = 19;
   localparam int Z_LSB = 0;

   typedef logic [COMP_W-1:0] comp_t;
   typedef logic [VEC_W-1:0]  vec_t;

   localparam comp_t SAT_POS = {1'b0, {(COMP_W-1){1'b1}}};
   localparam comp_t SAT_NEG = {1'b1, {(COMP_W-1){1'b0}}};

   typedef enum logic [2:0] {
      IDLE,
      ADD_X,
      ADD_Y,
      ADD_Z,
      DONE
   } state_e;

endpackage

// File: rtl/signed_vector_addition_seq_if.sv
// Operand/result handshake bundle; master drives operands and out_ready,
// slave (the adder) drives in_ready and the result.
interface signed_vector_addition_seq_if;
   import signed_vector_addition_seq_pkg::*;

   logic       in_valid;
   logic       in_ready;
   vec_t       in_vector_1;
   vec_t       in_vector_2;
   logic       out_valid;
   logic       out_ready;
   vec_t       out_vector;
   logic [2:0] out_overflow;

   modport master (
      output in_valid, in_vector_1, in_vector_2, out_ready,
      input  in_ready, out_valid, out_vector, out_overflow
   );

   modport slave (
      input  in_valid, in_vector_1, in_vector_2, out_ready,
      output in_ready, out_valid, out_vector, out_overflow
   );

endinterface

// File: rtl/signed_vector_addition_seq_component_adder.sv
// Combinational signed component adder with overflow flag; optional clamp to
// the representable range on overflow.
module signed_vector_addition_seq_component_adder
   import signed_vector_addition_seq_pkg::*;
#(
   parameter bit SATURATE = 1'b0
) (
   input  comp_t a_i,
   input  comp_t b_i,
   output comp_t sum_o,
   output logic  ovf_o
);

   logic [COMP_W:0] sum_wide;

   assign sum_wide = {a_i[COMP_W-1], a_i} + {b_i[COMP_W-1], b_i};
   // The extra top bit is the true sign; disagreement with the narrow sign means overflow.
   assign ovf_o    = sum_wide[COMP_W] ^ sum_wide[COMP_W-1];

   generate
      if (SATURATE) begin : g_sat
         assign sum_o = ovf_o ? (sum_wide[COMP_W] ? SAT_NEG : SAT_POS)
                              : sum_wide[COMP_W-1:0];
      end else begin : g_wrap
         assign sum_o = sum_wide[COMP_W-1:0];
      end
   endgenerate

endmodule

// File: rtl/signed_vector_addition_seq.sv
// Adds two packed signed 3-D vectors one component per cycle through a shared adder.
// Result valid 4 edges after accept (counting the accept edge); holds in DONE while out_ready is low.
module signed_vector_addition_seq
   import signed_vector_addition_seq_pkg::*;
#(
   parameter bit SATURATE = 1'b0
) (
   input  logic                         clk,
   input  logic                         rst_n,
   signed_vector_addition_seq_if.slave  bus
);

   state_e     state_q;
   vec_t       op1_q;
   vec_t       op2_q;
   vec_t       res_q;
   logic [2:0] ovf_q;
   logic       in_ready_q;
   logic       out_valid_q;

   comp_t      opa;
   comp_t      opb;
   comp_t      sum;
   logic       ovf;

   always_comb begin
      opa = op1_q[Z_LSB +: COMP_W];
      opb = op2_q[Z_LSB +: COMP_W];
      case (state_q)
         ADD_X: begin
            opa = op1_q[X_LSB +: COMP_W];
            opb = op2_q[X_LSB +: COMP_W];
         end
         ADD_Y: begin
            opa = op1_q[Y_LSB +: COMP_W];
            opb = op2_q[Y_LSB +: COMP_W];
         end
         default: ;
      endcase
   end

   signed_vector_addition_seq_component_adder #(
      .SATURATE (SATURATE)
   ) u_adder (
      .a_i   (opa),
      .b_i   (opb),
      .sum_o (sum),
      .ovf_o (ovf)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         op1_q       <= '0;
         op2_q       <= '0;
         res_q       <= '0;
         ovf_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.in_valid) begin
                  op1_q      <= bus.in_vector_1;
                  op2_q      <= bus.in_vector_2;
                  in_ready_q <= 1'b0;
                  state_q    <= ADD_X;
               end
            end
            ADD_X: begin
               res_q[X_LSB +: COMP_W] <= sum;
               ovf_q[2]               <= ovf;
               state_q                <= ADD_Y;
            end
            ADD_Y: begin
               res_q[Y_LSB +: COMP_W] <= sum;
               ovf_q[1]               <= ovf;
               state_q                <= ADD_Z;
            end
            ADD_Z: begin
               res_q[Z_LSB +: COMP_W] <= sum;
               ovf_q[0]               <= ovf;
               out_valid_q            <= 1'b1;
               state_q                <= DONE;
            end
            DONE: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= IDLE;
               end
            end
            default: begin
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
               state_q     <= IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready     = in_ready_q;
   assign bus.out_valid    = out_valid_q;
   assign bus.out_vector   = res_q;
   assign bus.out_overflow = ovf_q;

endmodule
